// File: rtl/l2_evict_write_buffer_pkg.sv
// Shared types for the L2 eviction write buffer: cache line container and FSM states.
package l2_evict_write_buffer_pkg;

    localparam int LINE_BITS = 256;

    typedef logic [LINE_BITS-1:0] cacheline_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } ewb_state_t;

endpackage

// File: rtl/l2_evict_write_buffer_line_fifo.sv
// Line storage for the eviction buffer: circular FIFO of {valid, tag, line}
// with a parallel tag match used for coalescing writes and servicing fills.
module ewb_line_fifo
    import l2_evict_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 27
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [TAG_W-1:0]         push_tag,
    input  logic [255:0]             push_data,
    input  logic                     ovr,
    input  logic [$clog2(DEPTH)-1:0] ovr_idx,
    input  logic [255:0]             ovr_data,
    input  logic                     pop,
    input  logic [TAG_W-1:0]         match_tag,
    output logic [DEPTH-1:0]         match,
    output logic [$clog2(DEPTH)-1:0] match_idx,
    output logic [255:0]             match_data,
    output logic [TAG_W-1:0]         head_tag,
    output logic [255:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0] valid;
    logic [TAG_W-1:0] tag_mem [DEPTH];
    cacheline_t       data_mem [DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload needs no reset: valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[tail]  <= push_tag;
            data_mem[tail] <= push_data;
        end
        if (ovr) begin
            data_mem[ovr_idx] <= ovr_data;
        end
    end

    always_comb begin
        match      = '0;
        match_idx  = '0;
        match_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (tag_mem[i] == match_tag);
            if (match[i]) begin
                match_idx  = IDX_W'(i);
                match_data = data_mem[i];
            end
        end
    end

    assign head_tag  = tag_mem[head];
    assign head_data = data_mem[head];

endmodule

// File: rtl/l2_evict_write_buffer.sv
// L2 pmem-side eviction write buffer: acks writebacks quickly, drains them when
// the L2 is idle, and serves line fills from buffered lines before going to pmem.
//
// state   | meaning
// S_IDLE  | arbitrate: read > write > drain
// S_READ  | line fill forwarded to pmem, waiting for pmem_resp
// S_DRAIN | head entry being written to pmem, not abortable
// S_RESP  | one-cycle mem_resp to the L2
module l2_evict_write_buffer
    import l2_evict_write_buffer_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int s_offset = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [255:0] mem_wdata,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic         ewb_stall,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int TAG_W = 32 - s_offset;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    ewb_state_t       state, state_n;
    cacheline_t       rdata_reg, rdata_n;
    logic             load_rdata;
    logic             push, ovr, pop;
    logic [TAG_W-1:0] line_tag;
    logic [DEPTH-1:0] match;
    logic [IDX_W-1:0] match_idx;
    cacheline_t       match_data;
    logic [TAG_W-1:0] head_tag;
    cacheline_t       head_data;
    logic [CNT_W-1:0] count;
    logic             hit, full;
    logic             unused_offset;

    assign line_tag      = mem_address[31:s_offset];
    assign unused_offset = ^mem_address[s_offset-1:0];
    assign hit           = |match;
    assign full          = (count == CNT_W'(DEPTH));

    ewb_line_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_tag   (line_tag),
        .push_data  (mem_wdata),
        .ovr        (ovr),
        .ovr_idx    (match_idx),
        .ovr_data   (mem_wdata),
        .pop        (pop),
        .match_tag  (line_tag),
        .match      (match),
        .match_idx  (match_idx),
        .match_data (match_data),
        .head_tag   (head_tag),
        .head_data  (head_data),
        .count      (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rdata_reg <= '0;
        end else begin
            state <= state_n;
            if (load_rdata) begin
                rdata_reg <= rdata_n;
            end
        end
    end

    always_comb begin
        state_n    = state;
        rdata_n    = match_data;
        load_rdata = 1'b0;
        push       = 1'b0;
        ovr        = 1'b0;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_read) begin
                    if (hit) begin
                        load_rdata = 1'b1;
                        state_n    = S_RESP;
                    end else begin
                        state_n = S_READ;
                    end
                end else if (mem_write) begin
                    if (hit) begin
                        ovr     = 1'b1;
                        state_n = S_RESP;
                    end else if (!full) begin
                        push    = 1'b1;
                        state_n = S_RESP;
                    end else begin
                        // L2 keeps the write asserted; it is taken after the drain frees a slot.
                        state_n = S_DRAIN;
                    end
                end else if (count != '0) begin
                    state_n = S_DRAIN;
                end
            end
            S_READ: begin
                if (pmem_resp) begin
                    rdata_n    = pmem_rdata;
                    load_rdata = 1'b1;
                    state_n    = S_RESP;
                end
            end
            S_DRAIN: begin
                if (pmem_resp) begin
                    pop     = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign mem_resp   = (state == S_RESP);
    assign mem_rdata  = mem_resp ? rdata_reg : '0;
    assign pmem_read  = (state == S_READ);
    assign pmem_write = (state == S_DRAIN);
    assign pmem_wdata = pmem_write ? head_data : '0;
    assign ewb_stall  = full | pmem_write;

    always_comb begin
        pmem_address = '0;
        if (pmem_read) begin
            pmem_address = {line_tag, {s_offset{1'b0}}};
        end else if (pmem_write) begin
            pmem_address = {head_tag, {s_offset{1'b0}}};
        end
    end

endmodule

// File: tb/tb_l2_evict_write_buffer.sv
// Directed bench for l2_evict_write_buffer with a fixed-latency pmem responder model.
module tb_l2_evict_write_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  mem_address;
    logic         mem_read, mem_write;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_resp, ewb_stall;
    logic [31:0]  pmem_address;
    logic         pmem_read, pmem_write;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    l2_evict_write_buffer #(.DEPTH(4), .s_offset(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .ewb_stall    (ewb_stall),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           w;
        logic [31:0]  a;
        logic [255:0] d;
    } ev_t;

    ev_t          log_q[$];
    int           tests = 0;
    int           fails = 0;
    int           acks = 0;
    int           resp_cnt = 0;
    int           both_cnt = 0;
    int           pm_lat = 3;
    logic [255:0] fill_pat = '0;

    function automatic logic [255:0] pat(input logic [7:0] b);
        return {32{b}};
    endfunction

    // pmem responder: holds off pm_lat cycles, aborts if the request vanishes.
    initial begin
        bit  ok;
        ev_t ev;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset && (pmem_read || pmem_write)) begin
                ok = 1'b1;
                for (int i = 0; i < pm_lat - 1; i++) begin
                    @(negedge clk);
                    if (reset || !(pmem_read || pmem_write)) begin
                        ok = 1'b0;
                        break;
                    end
                end
                if (ok) begin
                    ev.w = pmem_write;
                    ev.a = pmem_address;
                    ev.d = pmem_wdata;
                    log_q.push_back(ev);
                    pmem_rdata = fill_pat;
                    pmem_resp  = 1'b1;
                    @(negedge clk);
                    pmem_resp  = 1'b0;
                    pmem_rdata = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (pmem_read && pmem_write) both_cnt++;
        if (mem_resp) resp_cnt++;
    end

    task automatic do_req(input string nm, input bit w, input logic [31:0] a,
                          input logic [255:0] d, output int lat,
                          output logic [255:0] rd, output bit pm_busy);
        mem_address = a;
        mem_wdata   = d;
        mem_read    = !w;
        mem_write   = w;
        lat         = 0;
        rd          = '0;
        pm_busy     = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (mem_resp) begin
                lat     = i;
                rd      = mem_rdata;
                pm_busy = pmem_read | pmem_write;
                break;
            end
        end
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        tests++;
        if (lat == 0) begin
            fails++;
            $display("FAIL %s: no mem_resp within 200 cycles", nm);
        end else begin
            acks++;
        end
    endtask

    task automatic wait_log(input string nm, input int n);
        for (int i = 0; i < 300 && log_q.size() < n; i++) @(negedge clk);
        tests++;
        if (log_q.size() < n) begin
            fails++;
            $display("FAIL %s: pmem log size %0d, required %0d", nm, log_q.size(), n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        log_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({mem_resp, ewb_stall, pmem_read, pmem_write} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 0000", {mem_resp, ewb_stall, pmem_read, pmem_write});
        end
        tests++;
        if (pmem_address !== 32'h0) begin
            fails++;
            $display("FAIL reset_paddr: got %h required 0", pmem_address);
        end
        tests++;
        if (mem_rdata !== '0 || pmem_wdata !== '0) begin
            fails++;
            $display("FAIL reset_data: rdata %h wdata %h required 0", mem_rdata, pmem_wdata);
        end
        reset = 1'b0;
        log_q.delete();
    endtask

    task automatic test_write_drain();
        int lat; logic [255:0] rd; bit busy;
        do_reset();
        do_req("wr_1000", 1'b1, 32'h0000_1000, pat(8'hAA), lat, rd, busy);
        tests++;
        if (lat != 1 || busy) begin
            fails++;
            $display("FAIL wr_ack: lat %0d pmem_busy %0d, required lat 1 busy 0", lat, busy);
        end
        wait_log("wr_drain", 1);
        tests++;
        if (log_q[0].w !== 1'b1 || log_q[0].a !== 32'h0000_1000 || log_q[0].d !== pat(8'hAA)) begin
            fails++;
            $display("FAIL wr_drain_data: w %0d addr %h data %h, required 1 00001000 aa..", log_q[0].w, log_q[0].a, log_q[0].d);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (ewb_stall !== 1'b0 || pmem_write !== 1'b0) begin
            fails++;
            $display("FAIL wr_after_drain: stall %b pmem_write %b, required 0 0", ewb_stall, pmem_write);
        end
    endtask

    task automatic test_read_hit();
        int lat; logic [255:0] rd; bit busy;
        do_reset();
        do_req("hit_wr", 1'b1, 32'h0000_1000, pat(8'hAA), lat, rd, busy);
        // Issued while the DUT is still in S_RESP: one cycle to IDLE, one to respond.
        do_req("hit_rd", 1'b0, 32'h0000_1004, '0, lat, rd, busy);
        tests++;
        if (lat != 2 || rd !== pat(8'hAA) || log_q.size() != 0) begin
            fails++;
            $display("FAIL read_hit: lat %0d rdata %h pmem_ops %0d, required 2 aa.. 0", lat, rd, log_q.size());
        end
        wait_log("hit_drain", 1);
        repeat (10) @(negedge clk);
        tests++;
        if (log_q.size() != 1 || log_q[0].w !== 1'b1) begin
            fails++;
            $display("FAIL hit_no_pmem_read: ops %0d first_w %0d, required 1 1", log_q.size(), log_q[0].w);
        end
    endtask

    task automatic test_full();
        int lat; logic [255:0] rd; bit busy;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_req("full_fill", 1'b1, 32'h0000_4000 + 32'(i * 32), pat(8'(i + 1)), lat, rd, busy);
        end
        tests++;
        if (ewb_stall !== 1'b1) begin
            fails++;
            $display("FAIL full_stall: got %b required 1", ewb_stall);
        end
        do_req("full_5th", 1'b1, 32'h0000_4080, pat(8'h05), lat, rd, busy);
        tests++;
        if (lat != pm_lat + 3 || log_q.size() != 1) begin
            fails++;
            $display("FAIL full_5th_ack: lat %0d drains %0d, required %0d 1", lat, log_q.size(), pm_lat + 3);
        end
        tests++;
        if (log_q[0].a !== 32'h0000_4000 || log_q[0].d !== pat(8'h01)) begin
            fails++;
            $display("FAIL full_first_drain: addr %h data %h, required 00004000 01..", log_q[0].a, log_q[0].d);
        end
        wait_log("full_drains", 5);
        for (int i = 1; i < 5; i++) begin
            tests++;
            if (log_q[i].a !== 32'h0000_4000 + 32'(i * 32) || log_q[i].d !== pat(8'(i + 1))) begin
                fails++;
                $display("FAIL full_order[%0d]: addr %h data %h, required %h", i, log_q[i].a, log_q[i].d, 32'h4000 + 32'(i * 32));
            end
        end
    endtask

    task automatic test_coalesce();
        int lat; logic [255:0] rd; bit busy; int n2000; logic [255:0] d2000;
        do_reset();
        do_req("co_d1", 1'b1, 32'h0000_2000, pat(8'h21), lat, rd, busy);
        do_req("co_b", 1'b1, 32'h0000_5000, pat(8'h22), lat, rd, busy);
        do_req("co_c", 1'b1, 32'h0000_5020, pat(8'h23), lat, rd, busy);
        do_req("co_d", 1'b1, 32'h0000_5040, pat(8'h24), lat, rd, busy);
        do_req("co_d2", 1'b1, 32'h0000_2000, pat(8'h2F), lat, rd, busy);
        tests++;
        if (lat != 2 || ewb_stall !== 1'b1) begin
            fails++;
            $display("FAIL coalesce_ack: lat %0d stall %b, required 2 1", lat, ewb_stall);
        end
        wait_log("co_drains", 4);
        repeat (20) @(negedge clk);
        n2000 = 0;
        d2000 = '0;
        foreach (log_q[i]) if (log_q[i].a == 32'h0000_2000) begin n2000++; d2000 = log_q[i].d; end
        tests++;
        if (log_q.size() != 4 || n2000 != 1 || d2000 !== pat(8'h2F) || log_q[0].a !== 32'h0000_2000) begin
            fails++;
            $display("FAIL coalesce_drain: ops %0d writes_2000 %0d data %h first %h, required 4 1 2f.. 00002000",
                     log_q.size(), n2000, d2000, log_q[0].a);
        end
    endtask

    task automatic test_read_miss();
        int lat; logic [255:0] rd; bit busy;
        do_reset();
        fill_pat = pat(8'h5A);
        do_req("rm_w0", 1'b1, 32'h0000_6000, pat(8'h61), lat, rd, busy);
        do_req("rm_w1", 1'b1, 32'h0000_6020, pat(8'h62), lat, rd, busy);
        do_req("rm_rd", 1'b0, 32'h0000_3000, '0, lat, rd, busy);
        tests++;
        if (lat != pm_lat + 2 || rd !== pat(8'h5A)) begin
            fails++;
            $display("FAIL read_miss: lat %0d rdata %h, required %0d 5a..", lat, rd, pm_lat + 2);
        end
        tests++;
        if (log_q.size() != 1 || log_q[0].w !== 1'b0 || log_q[0].a !== 32'h0000_3000) begin
            fails++;
            $display("FAIL miss_first: ops %0d w %0d addr %h, required 1 0 00003000", log_q.size(), log_q[0].w, log_q[0].a);
        end
        wait_log("rm_drains", 3);
        tests++;
        if (log_q[1].a !== 32'h0000_6000 || log_q[1].d !== pat(8'h61) ||
            log_q[2].a !== 32'h0000_6020 || log_q[2].d !== pat(8'h62)) begin
            fails++;
            $display("FAIL miss_drain_order: %h %h, required 00006000 00006020", log_q[1].a, log_q[2].a);
        end
    endtask

    task automatic test_reset_drain();
        int lat; logic [255:0] rd; bit busy; bit seen;
        do_reset();
        do_req("rd_wr", 1'b1, 32'h0000_1000, pat(8'hAA), lat, rd, busy);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (pmem_write) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL rst_drain_start: pmem_write never rose within 50 cycles");
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if (pmem_write !== 1'b0 || ewb_stall !== 1'b0 || pmem_address !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid_drain: pmem_write %b stall %b addr %h, required 0 0 0", pmem_write, ewb_stall, pmem_address);
        end
        reset = 1'b0;
        log_q.delete();
        fill_pat = pat(8'hC3);
        do_req("rst_rd", 1'b0, 32'h0000_1000, '0, lat, rd, busy);
        tests++;
        if (lat != pm_lat + 1 || rd !== pat(8'hC3) || log_q.size() != 1 || log_q[0].w !== 1'b0 || log_q[0].a !== 32'h0000_1000) begin
            fails++;
            $display("FAIL rst_read_to_pmem: lat %0d rdata %h ops %0d addr %h, required %0d c3.. 1 00001000",
                     lat, rd, log_q.size(), log_q[0].a, pm_lat + 1);
        end
        repeat (20) @(negedge clk);
        tests++;
        if (log_q.size() != 1) begin
            fails++;
            $display("FAIL rst_discard: pmem ops %0d, required 1", log_q.size());
        end
    endtask

    task automatic test_invariants();
        tests++;
        if (both_cnt != 0) begin
            fails++;
            $display("FAIL rd_wr_overlap: cycles %0d, required 0", both_cnt);
        end
        tests++;
        if (resp_cnt != acks) begin
            fails++;
            $display("FAIL spurious_resp: resp cycles %0d, required %0d", resp_cnt, acks);
        end
    endtask

    initial begin
        reset       = 1'b1;
        mem_address = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wdata   = '0;
        test_reset();
        test_write_drain();
        test_read_hit();
        test_full();
        test_coalesce();
        test_read_miss();
        test_reset_drain();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
